// File: rtl/secded_pkg.sv
// SECDED helpers: code geometry, encoder and decoder over a fixed maximum width,
// specialised by the data_width argument at elaboration time.
package secded_pkg;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxCodeWidth = 72;

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
    logic                    single_err;
    logic                    double_err;
  } dec_t;

  function automatic int unsigned calc_parity_bits(input int unsigned data_width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (r == 0 && (32'd1 << i) >= data_width + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic int unsigned calc_code_width(input int unsigned data_width);
    return data_width + calc_parity_bits(data_width) + 1;
  endfunction

  function automatic logic is_pow2(input int unsigned v);
    return (v & (v - 1)) == 0;
  endfunction

  function automatic logic [MaxCodeWidth-1:0] encode(input logic [MaxDataWidth-1:0] data,
                                                      input int unsigned data_width);
    logic [MaxCodeWidth-1:0] code;
    int unsigned cw, r, di, cp;
    logic p;
    code = '0;
    cw   = calc_code_width(data_width);
    r    = calc_parity_bits(data_width);
    di   = 0;
    for (int unsigned pos = 1; pos < MaxCodeWidth; pos++) begin
      if (pos < cw && !is_pow2(pos)) begin
        code[pos[6:0]] = data[di[5:0]];
        di++;
      end
    end
    for (int unsigned i = 0; i < 7; i++) begin
      p = 1'b0;
      for (int unsigned pos = 1; pos < MaxCodeWidth; pos++) begin
        if (pos < cw && !is_pow2(pos) && pos[i[4:0]]) p ^= code[pos[6:0]];
      end
      cp = 32'd1 << i;
      if (i < r) code[cp[6:0]] = p;
    end
    // Bit 0 makes the whole codeword even parity.
    p = 1'b0;
    for (int unsigned pos = 1; pos < MaxCodeWidth; pos++) begin
      if (pos < cw) p ^= code[pos[6:0]];
    end
    code[0] = p;
    return code;
  endfunction

  function automatic dec_t decode(input logic [MaxCodeWidth-1:0] code,
                                  input int unsigned data_width);
    dec_t                    res;
    logic [MaxCodeWidth-1:0] fixed;
    logic [6:0]              syn;
    logic                    par;
    int unsigned             cw, di;
    cw  = calc_code_width(data_width);
    syn = '0;
    par = code[0];
    for (int unsigned pos = 1; pos < MaxCodeWidth; pos++) begin
      if (pos < cw && code[pos[6:0]]) begin
        syn ^= pos[6:0];
        par ^= 1'b1;
      end
    end
    res   = '0;
    fixed = code;
    if (par) begin
      if (syn == '0) begin
        res.single_err = 1'b1;
      end else if (32'(syn) < cw) begin
        fixed[syn]     = ~fixed[syn];
        res.single_err = 1'b1;
      end else begin
        res.double_err = 1'b1;
      end
    end else if (syn != '0) begin
      res.double_err = 1'b1;
    end
    di = 0;
    for (int unsigned pos = 1; pos < MaxCodeWidth; pos++) begin
      if (pos < cw && !is_pow2(pos)) begin
        res.data[di[5:0]] = fixed[pos[6:0]];
        di++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_ram.sv
// Single-port codeword storage: synchronous write, combinational read of the addressed word.
module secded_ram #(
  parameter int unsigned CODE_WIDTH = 22,
  parameter int unsigned RAM_DEPTH  = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [CODE_WIDTH-1:0] write_code,
  output logic [CODE_WIDTH-1:0] read_code
);

  logic [CODE_WIDTH-1:0] ram_data [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) ram_data[addr] <= write_code;
  end

  assign read_code = ram_data[addr];

endmodule

// File: rtl/secded_fpga_top.sv
// SECDED-protected RAM behind a CPU write/read port; reads correct single-bit errors
// and flag double-bit errors, with data and flags registered one cycle after the strobe.
module secded_fpga_top
  import secded_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RAM_DEPTH  = 64,
  localparam int unsigned ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_write_en,
  input  logic                  cpu_read_en,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  ecc_single_error,
  output logic                  ecc_double_error
);

  localparam int unsigned PARITY_BITS = calc_parity_bits(DATA_WIDTH);
  localparam int unsigned CODE_WIDTH  = DATA_WIDTH + PARITY_BITS + 1;

  logic                  addr_ok;
  logic [CODE_WIDTH-1:0] wr_code;
  logic [CODE_WIDTH-1:0] rd_code;
  dec_t                  dec;
  logic                  unused_data_hi;

  // Only non-power-of-two depths can present an address past the end of the array.
  assign addr_ok = {1'b0, cpu_addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH);

  always_comb begin
    wr_code = CODE_WIDTH'(encode(MaxDataWidth'(cpu_data_in), DATA_WIDTH));
    dec     = decode(MaxCodeWidth'(rd_code), DATA_WIDTH);
  end

  assign unused_data_hi = ^(dec.data >> DATA_WIDTH);

  secded_ram #(
    .CODE_WIDTH(CODE_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) ram_inst (
    .clk       (clk),
    .write_en  (cpu_write_en & addr_ok),
    .addr      (cpu_addr),
    .write_code(wr_code),
    .read_code (rd_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_data_out     <= '0;
      ecc_single_error <= 1'b0;
      ecc_double_error <= 1'b0;
    end else if (cpu_read_en) begin
      if (addr_ok) begin
        cpu_data_out     <= dec.data[DATA_WIDTH-1:0];
        ecc_single_error <= dec.single_err;
        ecc_double_error <= dec.double_err;
      end else begin
        cpu_data_out     <= '0;
        ecc_single_error <= 1'b0;
        ecc_double_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_secded_fpga_top.sv
// Directed bench for secded_fpga_top: vector table plus hand sequences for
// read-before-write and asynchronous reset.
module tb_secded_fpga_top;

  typedef enum logic [1:0] {OpWrite, OpRead, OpFlip, OpCode} op_t;

  typedef struct {
    op_t         op;
    logic [5:0]  addr;
    logic [15:0] data;      // write data, or expected read data
    int          bitpos;
    logic        exp_s;
    logic        exp_d;
    logic [21:0] exp_code;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_data_in = '0;
  logic [5:0]  cpu_addr = '0;
  logic        cpu_write_en = 1'b0;
  logic        cpu_read_en = 1'b0;
  logic [15:0] cpu_data_out;
  logic        ecc_single_error;
  logic        ecc_double_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] last_data = '0;
  logic        last_s = 1'b0;
  logic        last_d = 1'b0;

  vec_t vq[$];

  always #5 clk = ~clk;

  secded_fpga_top #(
    .DATA_WIDTH(16),
    .RAM_DEPTH (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_data_in     (cpu_data_in),
    .cpu_addr        (cpu_addr),
    .cpu_write_en    (cpu_write_en),
    .cpu_read_en     (cpu_read_en),
    .cpu_data_out    (cpu_data_out),
    .ecc_single_error(ecc_single_error),
    .ecc_double_error(ecc_double_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [15:0] d, input logic s,
                            input logic dd);
    check({name, ".data"}, 32'(cpu_data_out), 32'(d));
    check({name, ".single"}, 32'(ecc_single_error), 32'(s));
    check({name, ".double"}, 32'(ecc_double_error), 32'(dd));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_write_en = w;
    cpu_read_en  = r;
    cpu_addr     = a;
    cpu_data_in  = d;
    @(posedge clk);
    #1;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
  endtask

  function automatic vec_t mk(input op_t op, input logic [5:0] a, input logic [15:0] d,
                              input int b, input logic s, input logic dd,
                              input logic [21:0] c, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.bitpos = b;
    v.exp_s = s; v.exp_d = dd; v.exp_code = c; v.name = n;
    return v;
  endfunction

  initial begin
    // Hand-computed codewords: A5A5 -> 28B45F, 1234 -> 054742.
    vq.push_back(mk(OpWrite, 5,  16'hA5A5, 0,  0, 0, 22'h0,      "wr5"));
    vq.push_back(mk(OpCode,  5,  16'h0,    0,  0, 0, 22'h28B45F, "code5"));
    vq.push_back(mk(OpRead,  5,  16'hA5A5, 0,  0, 0, 22'h0,      "rd5_clean"));
    vq.push_back(mk(OpFlip,  5,  16'h0,    0,  0, 0, 22'h0,      "flip5_0"));
    vq.push_back(mk(OpRead,  5,  16'hA5A5, 0,  1, 0, 22'h0,      "rd5_par"));
    vq.push_back(mk(OpFlip,  5,  16'h0,    1,  0, 0, 22'h0,      "flip5_1"));
    vq.push_back(mk(OpRead,  5,  16'hA5A5, 0,  0, 1, 22'h0,      "rd5_dbl"));
    vq.push_back(mk(OpWrite, 9,  16'h1234, 0,  0, 0, 22'h0,      "wr9"));
    vq.push_back(mk(OpCode,  9,  16'h0,    0,  0, 0, 22'h054742, "code9"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    3,  0, 0, 22'h0,      "flip9_3"));
    vq.push_back(mk(OpRead,  9,  16'h1234, 0,  1, 0, 22'h0,      "rd9_d0"));
    vq.push_back(mk(OpRead,  9,  16'h1234, 0,  1, 0, 22'h0,      "rd9_d0_again"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    5,  0, 0, 22'h0,      "flip9_5"));
    vq.push_back(mk(OpRead,  9,  16'h1237, 0,  0, 1, 22'h0,      "rd9_d0d1"));
    vq.push_back(mk(OpWrite, 9,  16'h1234, 0,  0, 0, 22'h0,      "wr9b"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    16, 0, 0, 22'h0,      "flip9_16"));
    vq.push_back(mk(OpRead,  9,  16'h1234, 0,  1, 0, 22'h0,      "rd9_c16"));
    vq.push_back(mk(OpWrite, 9,  16'h1234, 0,  0, 0, 22'h0,      "wr9c"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    21, 0, 0, 22'h0,      "flip9_21"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    10, 0, 0, 22'h0,      "flip9_10"));
    vq.push_back(mk(OpFlip,  9,  16'h0,    1,  0, 0, 22'h0,      "flip9_1"));
    vq.push_back(mk(OpRead,  9,  16'h9214, 0,  0, 1, 22'h0,      "rd9_syn30"));
    vq.push_back(mk(OpWrite, 12, 16'h0F0F, 0,  0, 0, 22'h0,      "wr12"));
    vq.push_back(mk(OpRead,  12, 16'h0F0F, 0,  0, 0, 22'h0,      "rd12_clean"));
    vq.push_back(mk(OpFlip,  12, 16'h0,    21, 0, 0, 22'h0,      "flip12_21"));
    vq.push_back(mk(OpRead,  12, 16'h0F0F, 0,  1, 0, 22'h0,      "rd12_d15"));

    #2;
    check_outs("reset", 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      case (v.op)
        OpWrite: begin
          cycle(1'b1, 1'b0, v.addr, v.data);
          check_outs({v.name, ".hold"}, last_data, last_s, last_d);
        end
        OpRead: begin
          cycle(1'b0, 1'b1, v.addr, 16'h0);
          check_outs(v.name, v.data, v.exp_s, v.exp_d);
          last_data = v.data;
          last_s    = v.exp_s;
          last_d    = v.exp_d;
        end
        OpFlip: begin
          dut.ram_inst.ram_data[v.addr][v.bitpos] = ~dut.ram_inst.ram_data[v.addr][v.bitpos];
        end
        default: begin
          check(v.name, 32'(dut.ram_inst.ram_data[v.addr]), 32'(v.exp_code));
        end
      endcase
    end

    // Idle cycle: outputs hold the last read.
    cycle(1'b0, 1'b0, 6'd5, 16'h0);
    check_outs("idle_hold", 16'h0F0F, 1'b1, 1'b0);

    // Read-before-write on the same address.
    cycle(1'b1, 1'b0, 6'd2, 16'h0000);
    cycle(1'b1, 1'b1, 6'd2, 16'hFFFF);
    check_outs("rbw_old", 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 6'd2, 16'h0);
    check_outs("rbw_new", 16'hFFFF, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Address 5 still carries the two backdoor flips.
    cycle(1'b0, 1'b1, 6'd5, 16'h0);
    check_outs("post_rst_rd5", 16'hA5A5, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/secded_fpga_top.md
Name: secded_fpga_top

Overview:
- Single-port synchronous RAM with SECDED (Hamming plus overall parity) protection, wrapped as the FPGA top level behind a simple CPU-style write/read interface.
- Write data is encoded into a codeword and stored.
- On a read, the codeword is decoded: single-bit errors are corrected and flagged, double-bit errors are flagged only.

Parameters:
- DATA_WIDTH, 16, data word width in bits (supported range 4..64).
- RAM_DEPTH, 64, number of words.
- Derived PARITY_BITS: the smallest r with 2^r >= DATA_WIDTH+r+1 (5 for 16).
- Derived CODE_WIDTH = DATA_WIDTH+PARITY_BITS+1 (22 for 16).
- Derived ADDR_WIDTH = $clog2(RAM_DEPTH).

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_data_in  input  DATA_WIDTH  write data
- cpu_addr  input  ADDR_WIDTH  word address for read or write
- cpu_write_en  input  1  write strobe, sampled each rising edge
- cpu_read_en  input  1  read strobe, sampled each rising edge
- cpu_data_out  output  DATA_WIDTH  registered read data (corrected)
- ecc_single_error  output  1  registered; last read had a corrected single-bit error
- ecc_double_error  output  1  registered; last read had an uncorrectable double-bit error

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - cpu_data_out, ecc_single_error and ecc_double_error are 0 immediately on reset assertion.
  - Memory contents are not cleared; reading an unwritten location is undefined.
- Codeword layout (CODE_WIDTH bits, index 0..CODE_WIDTH-1):
  - Bit 0 is overall even parity: XOR of bits 1..CODE_WIDTH-1.
  - Positions 1..CODE_WIDTH-1 use Hamming numbering.
  - Positions that are powers of two (1,2,4,8,16) hold check bits.
  - Remaining positions hold data bits in ascending order, data[0] at position 3.
  - Check bit at position 2^i = XOR of the data bits whose position has bit i set.
- Write: with cpu_write_en=1 at a rising edge, ram_data[cpu_addr] <= encode(cpu_data_in). There is no output change.
- Read, 1-cycle latency: with cpu_read_en=1 at a rising edge, the stored codeword is decoded combinationally and cpu_data_out and both flags register on that same edge. They are valid after the edge and held until the next read or reset.
- Decode, with S = XOR of the positions (1..CODE_WIDTH-1) of all set bits, and P = XOR of all CODE_WIDTH bits:
  - S=0, P=0: clean; data out = extracted data; flags 0/0.
  - P=1, S=0: error in the overall parity bit; data uncorrected; flags 1/0.
  - P=1, 0<S<CODE_WIDTH: flip position S, then extract; flags 1/0.
  - P=1, S>=CODE_WIDTH: treat as uncorrectable; flags 0/1.
  - S!=0, P=0: double error; data out = raw extracted data (no correction); flags 0/1.
- Flags are never both 1.
- Simultaneous read and write:
  - Both operations execute.
  - The read returns the old contents (read-before-write).
  - Flags reflect the old contents.
- Addresses >= RAM_DEPTH (only possible for non-power-of-2 depth): writes are ignored; reads return 0 with flags 0/0.
- Backdoor access: the storage array is named ram_data (RAM_DEPTH x CODE_WIDTH), inside a sub-instance named ram_inst. Benches flip codeword bits hierarchically as ram_inst.ram_data[addr][bit].

Decomposition:
- Package secded_pkg holds:
  - functions computing PARITY_BITS and CODE_WIDTH from DATA_WIDTH;
  - the encode function;
  - the decode function, returning data, single and double.
- Sub-module secded_ram, instantiated as ram_inst:
  - holds the ram_data array;
  - performs a synchronous write of the codeword;
  - presents the read codeword.
- The top level holds encode and decode plus the output registers.

Test Plan:
- Reset, then write addr 5 = 16'hA5A5, then read addr 5 -> next cycle cpu_data_out=A5A5, flags 0/0.
- Flip ram_inst.ram_data[5][0] (overall parity bit), read -> A5A5, single=1, double=0.
- Additionally flip ram_inst.ram_data[5][1], read -> A5A5 (raw, uncorrected), single=0, double=1.
- Write addr 9 = 16'h1234, flip bit 3 (data[0]), read -> 1234 corrected, flags 1/0; the stored word stays erroneous, so a repeat read gives the same result.
- Write addr 2 = 16'hFFFF and read addr 2 in the same cycle after a prior write of 16'h0000 -> 0000 (read-before-write); the next read gives FFFF.
- Perform a read so outputs are nonzero, then assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge. After release, a read of addr 5 returns the stored codeword decoded.
